pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 5, number of pipeline stages (0=IF, 1=ID, 2=EX, 3=MEM, 4=WB).
REQ-002 SHALL have parameter PC_W, default 32, redirect-target width.
REQ-003 SHALL have ports: aclk  in  1  sole clock; areset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: id_valid in 1; id_rj, id_rk in 5 each; id_rj_used, id_rk_used in 1 each: ID source operands.
REQ-005 SHALL have ports: ex_valid, ex_we, ex_is_load, ex_is_div in 1 each; ex_rd in 5: EX destination.
REQ-006 SHALL have ports: mem_valid, mem_we, mem_is_load, mem_data_ok in 1 each; mem_rd in 5: MEM load completion.
REQ-007 SHALL have ports: div_done in 1: multi-cycle divider result ready.
REQ-008 SHALL have ports: ex_br_taken in 1; ex_br_target in PC_W: resolved taken branch.
REQ-009 SHALL have ports: wb_exc in 1 (exception or fetch-again); wb_exc_target in PC_W.
REQ-010 SHALL have ports: if_allow_in in 1: IF accepts redirect.
REQ-011 SHALL have ports: ready_go out NSTAGE; flush out NSTAGE; redirect_valid out 1; redirect_pc out PC_W.
REQ-012 SHALL have ports, under PERF_CNT_EN only: stall_cnt out 32; flush_cnt out 32.

Function
REQ-013 Load-use: ex_valid & ex_is_load & ex_we & ex_rd!=0 & (rj or rk match while used) SHALL drive ready_go[1]=0 combinationally.
REQ-014 MEM load pending: mem_valid & mem_is_load & mem_we & mem_rd!=0 & !mem_data_ok & match SHALL drive ready_go[1]=0.
REQ-015 Register 0 SHALL never cause a stall.
REQ-016 ex_valid & ex_is_div & !div_done SHALL drive ready_go[2]=0; ready_go[2]=1 in the div_done cycle.
REQ-017 All ready_go bits not forced low by REQ-013..016, REQ-021 SHALL be 1.
REQ-018 FSM states: RUN, WAIT_MEM, REDIRECT; encoding from the shared package.
REQ-019 RUN, wb_exc=1: flush[NSTAGE-1:0] all 1 same cycle; latch wb_exc_target; next state WAIT_MEM if a MEM load is pending (mem_valid & mem_is_load & !mem_data_ok), else REDIRECT.
REQ-020 WAIT_MEM: flush all 1 every cycle; leave to REDIRECT in the cycle after mem_data_ok=1.
REQ-021 REDIRECT: redirect_valid=1, redirect_pc=latched target, ready_go[0]=0; return to RUN on redirect_valid & if_allow_in (same-cycle handshake).
REQ-022 RUN, ex_valid & ex_br_taken & ready_go[2] & !wb_exc: flush[0] and flush[1]=1 one cycle; latch ex_br_target; enter REDIRECT.
REQ-023 wb_exc and a taken branch in the same cycle: exception wins, branch discarded.
REQ-024 wb_exc during WAIT_MEM/REDIRECT SHALL overwrite the latched target and re-run REQ-019 decision.
REQ-025 Branches SHALL be ignored outside RUN.
REQ-026 flush SHALL be 0 in all cases not listed above.

Reset
REQ-027 areset=1 SHALL immediately force state RUN, redirect_valid=0, redirect_pc=0, latched target=0, counters=0.
REQ-028 During reset ready_go SHALL be all 1, flush all 1 (combinational, async).
REQ-029 Reset mid-WAIT_MEM/REDIRECT SHALL drop the pending redirect without emitting it.

Configuration
REQ-030 Macro PERF_CNT_EN: defined -> stall_cnt increments each cycle ready_go[1]|ready_go[2] low, flush_cnt increments per flush event entry (REQ-019/022), both saturate at 0xFFFFFFFF; undefined -> ports and counters absent, no other change.

Structure
REQ-031 cpuDefine SHALL hold the FSM state enum hz_state_e and stage index constants IF_S..WB_S.
REQ-032 Operand match logic SHALL be one sub-module hazard_match (rd, we, valid, rj/rk, used -> hit), instantiated twice (EX, MEM).

Verification
REQ-033 EX load rd=5, ID rj=5 used -> ready_go[1]=0 one cycle, then 1; flush=0.
REQ-034 EX load rd=0, ID rj=0 -> no stall; ready_go=5'b11111.
REQ-035 Divide, div_done after 8 cycles -> ready_go[2]=0 for 8 cycles, 1 in cycle 9.
REQ-036 ex_br_taken target 0x1C000100, if_allow_in=1 -> flush=5'b00011 one cycle, next cycle redirect_valid=1 pc=0x1C000100, RUN after.
REQ-037 wb_exc target 0x1C008000 with pending MEM load, data_ok 3 cycles later -> flush=all 1 for 4 cycles, redirect_valid next cycle with 0x1C008000.
REQ-038 wb_exc and ex_br_taken same cycle -> redirect_pc=wb_exc_target; areset during REDIRECT -> redirect_valid=0 immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared hazard-control definitions: redirect FSM state type and stage indices.
package cpuDefine;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_WAIT_MEM = 2'd1,
      HZ_REDIRECT = 2'd2
   } hz_state_e;

   localparam int IF_S  = 0;
   localparam int ID_S  = 1;
   localparam int EX_S  = 2;
   localparam int MEM_S = 3;
   localparam int WB_S  = 4;

endpackage

// File: rtl/hazard_match.sv
// Source-operand match against one producer stage's destination register.
module hazard_match (
   input  logic       valid_i,
   input  logic       we_i,
   input  logic [4:0] rd_i,
   input  logic [4:0] rj_i,
   input  logic [4:0] rk_i,
   input  logic       rj_used_i,
   input  logic       rk_used_i,
   output logic       hit_o
);

   logic rj_hit;
   logic rk_hit;

   assign rj_hit = rj_used_i & (rj_i == rd_i);
   assign rk_hit = rk_used_i & (rk_i == rd_i);
   // r0 is hardwired zero, so a write to it never creates a dependency
   assign hit_o  = valid_i & we_i & (rd_i != 5'd0) & (rj_hit | rk_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush/redirect control; PERF_CNT_EN adds
// saturating stall and flush-event counters.
module pipeline_hazard_ctrl
   import cpuDefine::*;
#(
   parameter int NSTAGE = 5,
   parameter int PC_W   = 32
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              id_valid,
   input  logic [4:0]        id_rj,
   input  logic [4:0]        id_rk,
   input  logic              id_rj_used,
   input  logic              id_rk_used,
   input  logic              ex_valid,
   input  logic              ex_we,
   input  logic              ex_is_load,
   input  logic              ex_is_div,
   input  logic [4:0]        ex_rd,
   input  logic              mem_valid,
   input  logic              mem_we,
   input  logic              mem_is_load,
   input  logic              mem_data_ok,
   input  logic [4:0]        mem_rd,
   input  logic              div_done,
   input  logic              ex_br_taken,
   input  logic [PC_W-1:0]   ex_br_target,
   input  logic              wb_exc,
   input  logic [PC_W-1:0]   wb_exc_target,
   input  logic              if_allow_in,
   output logic [NSTAGE-1:0] ready_go,
   output logic [NSTAGE-1:0] flush,
   output logic              redirect_valid,
   output logic [PC_W-1:0]   redirect_pc
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   hz_state_e       state_q, state_d;
   logic [PC_W-1:0] tgt_q, tgt_d;
   logic            ex_hit;
   logic            mem_hit;
   logic            div_wait;
   logic            mem_pend;
   logic            br_req;

   hazard_match u_ex_match (
      .valid_i   (id_valid & ex_valid & ex_is_load),
      .we_i      (ex_we),
      .rd_i      (ex_rd),
      .rj_i      (id_rj),
      .rk_i      (id_rk),
      .rj_used_i (id_rj_used),
      .rk_used_i (id_rk_used),
      .hit_o     (ex_hit)
   );

   hazard_match u_mem_match (
      .valid_i   (id_valid & mem_valid & mem_is_load & ~mem_data_ok),
      .we_i      (mem_we),
      .rd_i      (mem_rd),
      .rj_i      (id_rj),
      .rk_i      (id_rk),
      .rj_used_i (id_rj_used),
      .rk_used_i (id_rk_used),
      .hit_o     (mem_hit)
   );

   assign div_wait = ex_valid & ex_is_div & ~div_done;
   assign mem_pend = mem_valid & mem_is_load & ~mem_data_ok;
   assign br_req   = (state_q == HZ_RUN) & ex_valid
                   & ex_br_taken & ~div_wait;

   always_comb begin
      ready_go = '1;
      flush    = '0;
      state_d  = state_q;
      tgt_d    = tgt_q;
      if (ex_hit | mem_hit) ready_go[ID_S] = 1'b0;
      if (div_wait)         ready_go[EX_S] = 1'b0;
      if (state_q == HZ_REDIRECT) ready_go[IF_S] = 1'b0;
      // an exception restarts the redirect sequence from any state
      if (wb_exc) begin
         flush   = '1;
         tgt_d   = wb_exc_target;
         state_d = mem_pend ? HZ_WAIT_MEM : HZ_REDIRECT;
      end else begin
         unique case (state_q)
            HZ_RUN: begin
               if (br_req) begin
                  flush[IF_S] = 1'b1;
                  flush[ID_S] = 1'b1;
                  tgt_d       = ex_br_target;
                  state_d     = HZ_REDIRECT;
               end
            end
            HZ_WAIT_MEM: begin
               flush = '1;
               if (mem_data_ok) state_d = HZ_REDIRECT;
            end
            HZ_REDIRECT: begin
               if (if_allow_in) state_d = HZ_RUN;
            end
            default: state_d = HZ_RUN;
         endcase
      end
      if (areset) begin
         ready_go = '1;
         flush    = '1;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= HZ_RUN;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

   assign redirect_valid = (state_q == HZ_REDIRECT);
   assign redirect_pc    = tgt_q;

`ifdef PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;
   logic        stall_evt;
   logic        flush_evt;

   assign stall_evt = ~(ready_go[ID_S] & ready_go[EX_S]);
   assign flush_evt = wb_exc | br_req;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_evt && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (flush_evt && flush_cnt_q != '1)
            flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios
// plus randomized traffic against a flag-based reference model.
module tb_pipeline_hazard_ctrl;

   logic        aclk = 1'b0;
   logic        areset;
   logic        id_valid;
   logic [4:0]  id_rj, id_rk;
   logic        id_rj_used, id_rk_used;
   logic        ex_valid, ex_we, ex_is_load, ex_is_div;
   logic [4:0]  ex_rd;
   logic        mem_valid, mem_we, mem_is_load, mem_data_ok;
   logic [4:0]  mem_rd;
   logic        div_done;
   logic        ex_br_taken;
   logic [31:0] ex_br_target;
   logic        wb_exc;
   logic [31:0] wb_exc_target;
   logic        if_allow_in;
   logic [4:0]  ready_go;
   logic [4:0]  flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   int n_run  = 0;
   int n_fail = 0;

   logic        m_wait;
   logic        m_redir;
   logic [31:0] m_tgt;

   pipeline_hazard_ctrl #(.NSTAGE(5), .PC_W(32)) dut (
      .aclk           (aclk),
      .areset         (areset),
      .id_valid       (id_valid),
      .id_rj          (id_rj),
      .id_rk          (id_rk),
      .id_rj_used     (id_rj_used),
      .id_rk_used     (id_rk_used),
      .ex_valid       (ex_valid),
      .ex_we          (ex_we),
      .ex_is_load     (ex_is_load),
      .ex_is_div      (ex_is_div),
      .ex_rd          (ex_rd),
      .mem_valid      (mem_valid),
      .mem_we         (mem_we),
      .mem_is_load    (mem_is_load),
      .mem_data_ok    (mem_data_ok),
      .mem_rd         (mem_rd),
      .div_done       (div_done),
      .ex_br_taken    (ex_br_taken),
      .ex_br_target   (ex_br_target),
      .wb_exc         (wb_exc),
      .wb_exc_target  (wb_exc_target),
      .if_allow_in    (if_allow_in),
      .ready_go       (ready_go),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef PERF_CNT_EN
      ,
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
`endif
   );

   always #5 aclk = ~aclk;

   task automatic clear_inputs();
      id_valid = 0; id_rj = 0; id_rk = 0;
      id_rj_used = 0; id_rk_used = 0;
      ex_valid = 0; ex_we = 0; ex_is_load = 0;
      ex_is_div = 0; ex_rd = 0;
      mem_valid = 0; mem_we = 0; mem_is_load = 0;
      mem_data_ok = 0; mem_rd = 0;
      div_done = 0; ex_br_taken = 0; ex_br_target = 0;
      wb_exc = 0; wb_exc_target = 0; if_allow_in = 0;
   endtask

   task automatic do_reset();
      areset = 1;
      clear_inputs();
      @(negedge aclk);
      @(negedge aclk);
      areset = 0;
      m_wait = 0; m_redir = 0; m_tgt = 0;
   endtask

   // Reference: does the ID instruction read register r (r0 never counts)?
   function automatic bit reads(input logic [4:0] r);
      return r != 5'd0 &&
             ((id_rj_used && id_rj == r) || (id_rk_used && id_rk == r));
   endfunction

   task automatic model_out(output logic [4:0] rg, output logic [4:0] fl,
                            output logic rv, output logic [31:0] pc);
      rg = 5'b11111;
      fl = 5'b00000;
      rv = 0;
      pc = 0;
      if (areset) begin
         fl = 5'b11111;
         return;
      end
      if (id_valid &&
          ((ex_valid && ex_is_load && ex_we && reads(ex_rd)) ||
           (mem_valid && mem_is_load && mem_we && !mem_data_ok &&
            reads(mem_rd))))
         rg[1] = 0;
      if (ex_valid && ex_is_div && !div_done) rg[2] = 0;
      if (m_redir) rg[0] = 0;
      if (wb_exc || m_wait) fl = 5'b11111;
      else if (!m_redir && ex_valid && ex_br_taken && rg[2]) fl = 5'b00011;
      rv = m_redir;
      pc = m_tgt;
   endtask

   task automatic model_step();
      if (areset) begin
         m_wait = 0; m_redir = 0; m_tgt = 0;
      end else if (wb_exc) begin
         m_tgt   = wb_exc_target;
         m_wait  = mem_valid && mem_is_load && !mem_data_ok;
         m_redir = !m_wait;
      end else if (m_wait) begin
         if (mem_data_ok) begin
            m_wait = 0; m_redir = 1;
         end
      end else if (m_redir) begin
         if (if_allow_in) m_redir = 0;
      end else if (ex_valid && ex_br_taken &&
                   !(ex_is_div && !div_done)) begin
         m_tgt = ex_br_target; m_redir = 1;
      end
   endtask

   task automatic test_reset();
      areset = 1;
      clear_inputs();
      ex_valid = 1; ex_is_load = 1; ex_we = 1; ex_rd = 5'd4;
      id_valid = 1; id_rj = 5'd4; id_rj_used = 1; ex_is_div = 1;
      #2;
      n_run++; if (ready_go !== 5'b11111) begin n_fail++; $display("FAIL rst_rg: got %b want %b", ready_go, 5'b11111); end
      n_run++; if (flush !== 5'b11111) begin n_fail++; $display("FAIL rst_flush: got %b want %b", flush, 5'b11111); end
      n_run++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rv: got %b want 0", redirect_valid); end
      n_run++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", redirect_pc); end
      @(negedge aclk);
      areset = 0;
      clear_inputs();
      #2;
      n_run++; if (flush !== 5'b00000) begin n_fail++; $display("FAIL rst_rel_flush: got %b want %b", flush, 5'b00000); end
      n_run++; if (ready_go !== 5'b11111) begin n_fail++; $display("FAIL rst_rel_rg: got %b want %b", ready_go, 5'b11111); end
      @(negedge aclk);
   endtask

   task automatic test_load_use();
      do_reset();
      ex_valid = 1; ex_is_load = 1; ex_we = 1; ex_rd = 5'd5;
      id_valid = 1; id_rj = 5'd5; id_rj_used = 1;
      #2;
      n_run++; if (ready_go !== 5'b11101) begin n_fail++; $display("FAIL lu_rg: got %b want %b", ready_go, 5'b11101); end
      n_run++; if (flush !== 5'b00000) begin n_fail++; $display("FAIL lu_flush: got %b want %b", flush, 5'b00000); end
      @(negedge aclk);
      ex_valid = 0;
      #2;
      n_run++; if (ready_go !== 5'b11111) begin n_fail++; $display("FAIL lu_after_rg: got %b want %b", ready_go, 5'b11111); end
      @(negedge aclk);
      ex_valid = 1; id_rj = 5'd1; id_rk = 5'd5;
      id_rj_used = 1; id_rk_used = 0;
      #2;
      n_run++; if (ready_go !== 5'b11111) begin n_fail++; $display("FAIL lu_rk_unused: got %b want %b", ready_go, 5'b11111); end
      @(negedge aclk);
      id_rk_used = 1;
      #2;
      n_run++; if (ready_go !== 5'b11101) begin n_fail++; $display("FAIL lu_rk_used: got %b want %b", ready_go, 5'b11101); end
      @(negedge aclk);
      clear_inputs();
      ex_valid = 1; ex_is_load = 1; ex_we = 1; ex_rd = 5'd0;
      id_valid = 1; id_rj = 5'd0; id_rj_used = 1;
      id_rk = 5'd0; id_rk_used = 1;
      #2;
      n_run++; if (ready_go !== 5'b11111) begin n_fail++; $display("FAIL r0_rg: got %b want %b", ready_go, 5'b11111); end
      @(negedge aclk);
      clear_inputs();
   endtask

   task automatic test_mem_pending();
      do_reset();
      mem_valid = 1; mem_is_load = 1; mem_we = 1; mem_rd = 5'd9;
      id_valid = 1; id_rk = 5'd9; id_rk_used = 1;
      #2;
      n_run++; if (ready_go !== 5'b11101) begin n_fail++; $display("FAIL mem_rg: got %b want %b", ready_go, 5'b11101); end
      @(negedge aclk);
      mem_data_ok = 1;
      #2;
      n_run++; if (ready_go !== 5'b11111) begin n_fail++; $display("FAIL mem_ok_rg: got %b want %b", ready_go, 5'b11111); end
      @(negedge aclk);
      clear_inputs();
   endtask

   task automatic test_div();
      do_reset();
      ex_valid = 1; ex_is_div = 1; div_done = 0;
      for (int i = 0; i < 8; i++) begin
         #2;
         n_run++; if (ready_go[2] !== 1'b0) begin n_fail++; $display("FAIL div_wait cyc %0d: got %b want 0", i, ready_go[2]); end
         @(negedge aclk);
      end
      div_done = 1;
      #2;
      n_run++; if (ready_go !== 5'b11111) begin n_fail++; $display("FAIL div_done_rg: got %b want %b", ready_go, 5'b11111); end
      @(negedge aclk);
      clear_inputs();
   endtask

   task automatic test_branch();
      do_reset();
      ex_valid = 1; ex_br_taken = 1; ex_br_target = 32'h1C00_0100;
      if_allow_in = 1;
      #2;
      n_run++; if (flush !== 5'b00011) begin n_fail++; $display("FAIL br_flush: got %b want %b", flush, 5'b00011); end
      n_run++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL br_rv0: got %b want 0", redirect_valid); end
      @(negedge aclk);
      ex_valid = 0; ex_br_taken = 0;
      #2;
      n_run++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL br_rv: got %b want 1", redirect_valid); end
      n_run++; if (redirect_pc !== 32'h1C00_0100) begin n_fail++; $display("FAIL br_pc: got %h want %h", redirect_pc, 32'h1C00_0100); end
      n_run++; if (ready_go !== 5'b11110) begin n_fail++; $display("FAIL br_rg: got %b want %b", ready_go, 5'b11110); end
      n_run++; if (flush !== 5'b00000) begin n_fail++; $display("FAIL br_flush2: got %b want %b", flush, 5'b00000); end
      @(negedge aclk);
      #2;
      n_run++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL br_run: got %b want 0", redirect_valid); end
      @(negedge aclk);
      clear_inputs();
   endtask

   task automatic test_exc_wait_mem();
      do_reset();
      mem_valid = 1; mem_is_load = 1; mem_we = 1; mem_rd = 5'd3;
      wb_exc = 1; wb_exc_target = 32'h1C00_8000; if_allow_in = 1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_data_ok = 1;
         #2;
         n_run++; if (flush !== 5'b11111) begin n_fail++; $display("FAIL exc_flush cyc %0d: got %b want %b", i, flush, 5'b11111); end
         n_run++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL exc_rv0 cyc %0d: got %b want 0", i, redirect_valid); end
         @(negedge aclk);
         wb_exc = 0;
      end
      mem_valid = 0; mem_data_ok = 0;
      #2;
      n_run++; if (flush !== 5'b00000) begin n_fail++; $display("FAIL exc_flush_end: got %b want %b", flush, 5'b00000); end
      n_run++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL exc_rv: got %b want 1", redirect_valid); end
      n_run++; if (redirect_pc !== 32'h1C00_8000) begin n_fail++; $display("FAIL exc_pc: got %h want %h", redirect_pc, 32'h1C00_8000); end
      @(negedge aclk);
      #2;
      n_run++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL exc_run: got %b want 0", redirect_valid); end
      @(negedge aclk);
      clear_inputs();
   endtask

   task automatic test_exc_vs_branch();
      do_reset();
      wb_exc = 1; wb_exc_target = 32'h1C00_2000;
      ex_valid = 1; ex_br_taken = 1; ex_br_target = 32'h1C00_4000;
      #2;
      n_run++; if (flush !== 5'b11111) begin n_fail++; $display("FAIL eb_flush: got %b want %b", flush, 5'b11111); end
      @(negedge aclk);
      clear_inputs();
      #2;
      n_run++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL eb_rv: got %b want 1", redirect_valid); end
      n_run++; if (redirect_pc !== 32'h1C00_2000) begin n_fail++; $display("FAIL eb_pc: got %h want %h", redirect_pc, 32'h1C00_2000); end
      @(negedge aclk);
      areset = 1;
      #1;
      n_run++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL eb_rst_rv: got %b want 0", redirect_valid); end
      n_run++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL eb_rst_pc: got %h want 0", redirect_pc); end
      @(negedge aclk);
      areset = 0; if_allow_in = 1;
      #2;
      n_run++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL eb_dropped: got %b want 0", redirect_valid); end
      @(negedge aclk);
      clear_inputs();
   endtask

   task automatic test_random();
      logic [4:0]  e_rg, e_fl;
      logic        e_rv;
      logic [31:0] e_pc;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         areset        = ($urandom_range(0, 63) == 0);
         id_valid      = ($urandom_range(0, 3) != 0);
         id_rj         = 5'($urandom_range(0, 3));
         id_rk         = 5'($urandom_range(0, 3));
         id_rj_used    = 1'($urandom_range(0, 1));
         id_rk_used    = 1'($urandom_range(0, 1));
         ex_valid      = 1'($urandom_range(0, 1));
         ex_we         = ($urandom_range(0, 3) != 0);
         ex_is_load    = 1'($urandom_range(0, 1));
         ex_is_div     = ($urandom_range(0, 3) == 0);
         ex_rd         = 5'($urandom_range(0, 3));
         mem_valid     = 1'($urandom_range(0, 1));
         mem_we        = ($urandom_range(0, 3) != 0);
         mem_is_load   = 1'($urandom_range(0, 1));
         mem_data_ok   = ($urandom_range(0, 2) == 0);
         mem_rd        = 5'($urandom_range(0, 3));
         div_done      = ($urandom_range(0, 2) == 0);
         ex_br_taken   = ($urandom_range(0, 3) == 0);
         ex_br_target  = $urandom;
         wb_exc        = ($urandom_range(0, 15) == 0);
         wb_exc_target = $urandom;
         if_allow_in   = 1'($urandom_range(0, 1));
         #2;
         model_out(e_rg, e_fl, e_rv, e_pc);
         n_run++; if (ready_go !== e_rg) begin n_fail++; $display("FAIL rand_rg cyc %0d: got %b want %b", c, ready_go, e_rg); end
         n_run++; if (flush !== e_fl) begin n_fail++; $display("FAIL rand_flush cyc %0d: got %b want %b", c, flush, e_fl); end
         n_run++; if (redirect_valid !== e_rv) begin n_fail++; $display("FAIL rand_rv cyc %0d: got %b want %b", c, redirect_valid, e_rv); end
         n_run++; if (redirect_pc !== e_pc) begin n_fail++; $display("FAIL rand_pc cyc %0d: got %h want %h", c, redirect_pc, e_pc); end
         model_step();
         @(negedge aclk);
      end
      areset = 0;
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_mem_pending();
      test_div();
      test_branch();
      test_exc_wait_mem();
      test_exc_vs_branch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
